// File: rtl/threshold_detector.sv
`default_nettype none
// ============================================================================
// threshold_detector -- alarms when a feature stays above baseline*THRESH_MULT
// for PERSIST samples, then ignores HOLDOFF samples after the alarm clears.
// Optional macro DETECT_HYST_EN: alarm exit requires feat <= threshold/2.
// Rev 1.0
// ============================================================================
module threshold_detector #(
  parameter int FEAT_WIDTH  = 25,
  parameter int BASE_WIDTH  = 34,
  parameter int THRESH_MULT = 3,
  parameter int PERSIST     = 4,
  parameter int HOLDOFF     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [FEAT_WIDTH-1:0] feat_in,
  input  logic                         feat_valid,
  input  logic signed [BASE_WIDTH-1:0] base_in,
  input  logic                         base_valid,
  output logic                         above,
  output logic                         detect,
  output logic                         alarm,
  output logic [7:0]                   run_count,
  output logic                         data_valid
);

  localparam int TW = BASE_WIDTH + 4;

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_MONITOR   = 3'd1;
  localparam logic [2:0] c_CANDIDATE = 3'd2;
  localparam logic [2:0] c_ALARM     = 3'd3;
  localparam logic [2:0] c_HLDOFF    = 3'd4;

  localparam logic signed [TW-1:0] c_mult        = TW'(THRESH_MULT);
  localparam logic [7:0]           c_persist     = 8'(PERSIST);
  localparam logic [7:0]           c_holdoff     = 8'(HOLDOFF);
  localparam bit                   c_persist_one = (PERSIST == 1);

  logic [2:0]                   state_q, state_d;
  logic signed [BASE_WIDTH-1:0] base_q;
  logic [7:0]                   run_q, run_d;
  logic [7:0]                   hold_q, hold_d;
  logic                         above_q, above_d;
  logic                         detect_q, detect_d;
  logic                         alarm_q, alarm_d;
  logic                         valid_q, valid_d;

  logic                         w_accept;
  logic                         w_capture;
  logic                         w_above;
  logic                         w_exit;
  logic                         w_reach;
  logic [7:0]                   w_run_inc;
  logic signed [TW-1:0]         w_feat;
  logic signed [TW-1:0]         w_thresh;

  assign w_accept  = feat_valid & ~en;
  assign w_capture = base_valid & ~en;

  // THRESH_MULT <= 15 fits in the 4 guard bits, so the product never truncates
  assign w_feat    = $signed({{(TW-FEAT_WIDTH){feat_in[FEAT_WIDTH-1]}}, feat_in});
  assign w_thresh  = $signed({{4{base_q[BASE_WIDTH-1]}}, base_q}) * c_mult;
  assign w_above   = (state_q != c_IDLE) && (w_feat > w_thresh);
  assign w_run_inc = run_q + 8'd1;
  assign w_reach   = (w_run_inc == c_persist);

`ifdef DETECT_HYST_EN
  logic signed [TW-1:0] w_half;
  assign w_half = w_thresh >>> 1;
  assign w_exit = (w_feat <= w_half);
`else
  assign w_exit = ~w_above;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_capture) state_d = c_MONITOR;
      end
      c_MONITOR: begin
        if (w_accept && w_above) state_d = c_persist_one ? c_ALARM : c_CANDIDATE;
      end
      c_CANDIDATE: begin
        if (w_accept) begin
          if (!w_above)     state_d = c_MONITOR;
          else if (w_reach) state_d = c_ALARM;
        end
      end
      c_ALARM: begin
        if (w_accept && !w_above && w_exit) state_d = c_HLDOFF;
      end
      c_HLDOFF: begin
        if (w_accept && (hold_q <= 8'd1)) state_d = c_MONITOR;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    run_d    = run_q;
    hold_d   = hold_q;
    above_d  = above_q;
    detect_d = 1'b0;
    alarm_d  = alarm_q;
    valid_d  = 1'b0;
    if (w_accept) begin
      valid_d = 1'b1;
      above_d = w_above;
      case (state_q)
        c_MONITOR: begin
          if (w_above) begin
            run_d = 8'd1;
            if (c_persist_one) begin
              detect_d = 1'b1;
              alarm_d  = 1'b1;
            end
          end
        end
        c_CANDIDATE: begin
          if (w_above) begin
            run_d = w_run_inc;
            if (w_reach) begin
              detect_d = 1'b1;
              alarm_d  = 1'b1;
            end
          end else begin
            run_d = 8'd0;
          end
        end
        c_ALARM: begin
          if (w_above) begin
            if (run_q != 8'hFF) run_d = w_run_inc;
          end else if (w_exit) begin
            alarm_d = 1'b0;
            run_d   = 8'd0;
            hold_d  = c_holdoff;
          end
        end
        c_HLDOFF: begin
          if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      run_q    <= 8'd0;
      hold_q   <= 8'd0;
      above_q  <= 1'b0;
      detect_q <= 1'b0;
      alarm_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      // the compare above used the old base_q, so a same-cycle capture applies next sample
      if (w_capture) base_q <= base_in;
      run_q    <= run_d;
      hold_q   <= hold_d;
      above_q  <= above_d;
      detect_q <= detect_d;
      alarm_q  <= alarm_d;
      valid_q  <= valid_d;
    end
  end

  assign above      = above_q;
  assign detect     = detect_q;
  assign alarm      = alarm_q;
  assign run_count  = run_q;
  assign data_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_threshold_detector.sv
`default_nettype none
// ============================================================================
// tb_threshold_detector -- directed and randomized checks of threshold_detector
// against a sample-level behavioural model. Rev 1.0
// ============================================================================
module tb_threshold_detector;

  localparam int FW   = 25;
  localparam int BW   = 34;
  localparam int MULT = 3;
  localparam int PERS = 4;
  localparam int HOLD = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 feat_valid = 1'b0;
  logic                 base_valid = 1'b0;
  logic signed [FW-1:0] feat_in = '0;
  logic signed [BW-1:0] base_in = '0;
  logic                 above, detect, alarm, data_valid;
  logic [7:0]           run_count;

  int total = 0;
  int bad   = 0;

  // model: whether a baseline exists, the baseline, alarm flag, streak length, cooldown left
  bit     m_have_base, m_alarm, m_above, m_det, m_dv;
  longint m_base;
  int     m_run, m_cool;

  always #5 clk = ~clk;

  threshold_detector #(
    .FEAT_WIDTH (FW),
    .BASE_WIDTH (BW),
    .THRESH_MULT(MULT),
    .PERSIST    (PERS),
    .HOLDOFF    (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .feat_in   (feat_in),
    .feat_valid(feat_valid),
    .base_in   (base_in),
    .base_valid(base_valid),
    .above     (above),
    .detect    (detect),
    .alarm     (alarm),
    .run_count (run_count),
    .data_valid(data_valid)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit fv, input longint f,
                            input bit bv, input longint b);
    longint thr;
    bit     a, leave;
    if (r) begin
      m_have_base = 0; m_base = 0; m_alarm = 0; m_above = 0;
      m_det = 0; m_dv = 0; m_run = 0; m_cool = 0;
      return;
    end
    m_det = 0;
    m_dv  = 0;
    if (!e && fv) begin
      thr = m_base * MULT;
      a   = m_have_base && (f > thr);
`ifdef DETECT_HYST_EN
      leave = (f <= (thr >>> 1));
`else
      leave = !a;
`endif
      m_dv    = 1;
      m_above = a;
      if (!m_have_base) begin
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_alarm) begin
        if (a) m_run = (m_run < 255) ? m_run + 1 : 255;
        else if (leave) begin
          m_alarm = 0; m_run = 0; m_cool = HOLD;
        end
      end else if (a) begin
        m_run++;
        if (m_run >= PERS) begin
          m_alarm = 1; m_det = 1;
        end
      end else begin
        m_run = 0;
      end
    end
    if (!e && bv) begin
      m_have_base = 1;
      m_base      = b;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit fv, input longint f,
                      input bit bv, input longint b, input string tag);
    @(negedge clk);
    rst        = r;
    en         = e;
    feat_valid = fv;
    feat_in    = f[FW-1:0];
    base_valid = bv;
    base_in    = b[BW-1:0];
    model_step(r, e, fv, f, bv, b);
    @(posedge clk);
    #1;
    chk({tag, ".above"},      above,      m_above);
    chk({tag, ".detect"},     detect,     m_det);
    chk({tag, ".alarm"},      alarm,      m_alarm);
    chk({tag, ".run_count"},  run_count,  m_run);
    chk({tag, ".data_valid"}, data_valid, m_dv);
  endtask

  task automatic sample(input longint f, input string tag);
    step(0, 0, 1, f, 0, 0, tag);
  endtask

  task automatic capture(input longint b, input string tag);
    step(0, 0, 0, 0, 1, b, tag);
  endtask

  initial begin
    int     runs [5];
    longint f, b;
    bit     r, e, fv, bv;

    step(1, 0, 1, 777, 1, 55, "reset");
    chk("reset.alarm_zero", alarm, 0);
    sample(1000, "nobase");
    chk("nobase.above_zero", above, 0);
    step(0, 1, 1, 1000, 1, 7, "idle_en_hi");
    capture(100, "cap100");

    for (int i = 0; i < 4; i++) begin
      sample(301, "onset");
      chk("onset.detect_only_4th", detect, (i == 3));
    end
    chk("onset.run4", run_count, 4);
    step(0, 1, 1, 0, 1, 9, "frozen");
    sample(301, "alarm_cont");
    sample(0, "alarm_exit");
    chk("alarm_exit.alarm_zero", alarm, 0);
    for (int i = 0; i < 16; i++) sample(1000, "holdoff");
    chk("holdoff.run_zero", run_count, 0);
    sample(1000, "post_hold");
    chk("post_hold.run1", run_count, 1);
    for (int i = 0; i < 3; i++) sample(301, "realarm");
`ifdef DETECT_HYST_EN
    sample(200, "hyst_keep");
    chk("hyst_keep.alarm", alarm, 1);
    sample(150, "hyst_exit");
    chk("hyst_exit.alarm", alarm, 0);
`else
    sample(300, "plain_exit");
    chk("plain_exit.alarm", alarm, 0);
`endif

    step(1, 0, 0, 0, 0, 0, "reset2");
    capture(100, "cap100b");
    for (int i = 0; i < 10; i++) sample(300, "equal_thr");

    runs = '{1, 2, 3, 0, 1};
    f = 301;
    for (int i = 0; i < 5; i++) begin
      sample((i == 3) ? 50 : f, "broken_run");
      chk("broken_run.seq", run_count, runs[i]);
    end

    step(1, 0, 0, 0, 0, 0, "reset3");
    capture(-5, "cap_neg");
    sample(-14, "neg_above");
    chk("neg_above.above1", above, 1);
    sample(-15, "neg_equal");
    chk("neg_equal.above0", above, 0);
    step(0, 0, 1, 301, 1, 200, "same_cycle");
    chk("same_cycle.old_base", above, 1);
    sample(301, "new_base");
    chk("new_base.above0", above, 0);

    step(1, 0, 0, 0, 0, 0, "reset4");
    capture(100, "cap100c");
    for (int i = 0; i < 4; i++) sample(400, "pre_rst");
    step(1, 1, 1, 1000, 1, 3, "rst_in_alarm");
    chk("rst_in_alarm.alarm0", alarm, 0);
    sample(1000, "rst_nobase");
    chk("rst_nobase.valid", data_valid, 1);

    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) == 0);
      fv = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 15) == 0);
      b  = longint'(int'($urandom_range(0, 300)) - 60);
      f  = m_base * MULT + longint'(int'($urandom_range(0, 60)) - 25);
      if ($urandom_range(0, 19) == 0) f = ($urandom_range(0, 1) == 0) ? -(64'sd1 <<< 24) : (64'sd1 <<< 24) - 1;
      step(r, e, fv, f, bv, b, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/threshold_detector.md
THRESHOLD_DETECTOR -- requirements
Module: threshold_detector

Interface
REQ-001 SHALL have parameter FEAT_WIDTH, default 25: signed feature sample width.
REQ-002 SHALL have parameter BASE_WIDTH, default 34: signed width of the baseline from the upstream baseline stage.
REQ-003 SHALL have parameter THRESH_MULT, default 3: unsigned integer multiplier of the baseline, range 1..15.
REQ-004 SHALL have parameter PERSIST, default 4: consecutive above-threshold samples needed to raise an alarm, range 1..255.
REQ-005 SHALL have parameter HOLDOFF, default 16: samples ignored after an alarm ends, range 1..255.
REQ-006 SHALL have ports, one clock, reset synchronous active-high:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- en  in  1  active-low enable
- feat_in  in  FEAT_WIDTH  signed feature value
- feat_valid  in  1  feat_in qualifier
- base_in  in  BASE_WIDTH  signed baseline, already shifted
- base_valid  in  1  base_in qualifier, from the baseline stage data_valid
- above  out  1  registered result of the last compare
- detect  out  1  one-cycle alarm-onset pulse
- alarm  out  1  alarm level
- run_count  out  8  current consecutive above count
- data_valid  out  1  one-cycle pulse, compare result updated

Function
REQ-007 A sample SHALL be accepted when feat_valid=1 and en=0; a baseline SHALL be captured into base_reg when base_valid=1 and en=0.
REQ-008 threshold SHALL be base_reg*THRESH_MULT, computed signed at BASE_WIDTH+4 bits with no truncation; feat_in SHALL be sign-extended to that width.
REQ-009 above SHALL be 1 when feat > threshold, strictly. Equal SHALL compare as 0.
REQ-010 above and data_valid SHALL update on the edge that accepts the sample: latency 1 cycle.
REQ-011 If base_valid and feat_valid occur in the same cycle, the compare SHALL use the previous base_reg. The new baseline SHALL apply from the next sample.
REQ-012 The FSM SHALL have states IDLE, MONITOR, CANDIDATE, ALARM and HLDOFF.
REQ-013 IDLE: no baseline captured yet. Accepted samples SHALL pulse data_valid with above=0. The first capture SHALL move the FSM to MONITOR.
REQ-014 MONITOR, on an above sample: run_count SHALL become 1 and the FSM SHALL go to CANDIDATE. If PERSIST=1 it SHALL go directly to ALARM with detect.
REQ-015 CANDIDATE: an above sample SHALL increment run_count, and reaching PERSIST SHALL enter ALARM. A non-above sample SHALL clear run_count and return to MONITOR.
REQ-016 On entry to ALARM, detect SHALL be 1 for exactly the data_valid cycle of the PERSIST-th sample, and alarm SHALL be 1 in the same cycle.
REQ-017 ALARM SHALL persist while samples stay above; run_count SHALL saturate at 255.
REQ-018 The first non-above sample in ALARM SHALL clear alarm and run_count, load a hold counter with HOLDOFF, and enter HLDOFF.
REQ-019 HLDOFF: each accepted sample SHALL decrement the hold counter, with above still reported but not counted. When the counter reaches 0, the FSM SHALL return to MONITOR. The next sample SHALL be evaluated normally.
REQ-020 With en=1: no acceptance, no capture, state and counters frozen, detect and data_valid held 0, other outputs held.
REQ-021 A baseline capture in any state other than IDLE SHALL NOT change the state or counters.

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL enter IDLE with base_reg=0, the hold counter at 0 and all outputs 0 on that edge, regardless of en or valids.
REQ-023 Reset asserted during ALARM SHALL drop alarm on the same edge. After reset, a fresh baseline SHALL be required.

Configuration
REQ-024 With macro DETECT_HYST_EN defined, exit from ALARM SHALL require feat <= (threshold >>> 1), arithmetic shift. Samples between the two levels SHALL keep ALARM without incrementing run_count.
REQ-025 Without DETECT_HYST_EN, exit from ALARM SHALL occur on any non-above sample (REQ-018), and no half-threshold logic SHALL be synthesized.

Verification (THRESH_MULT=3, PERSIST=4, HOLDOFF=16)
REQ-026 base_in=100 captured, then feat 301 x4 -> detect=1 only on the 4th data_valid; alarm=1; run_count=4.
REQ-027 base=100, feat 300 x10 -> above=0 on every sample; detect is never asserted; the FSM stays in MONITOR.
REQ-028 base=100, feats 301,301,301,50,301 -> run_count goes 1,2,3,0,1; no detect.
REQ-029 In ALARM, feat 0 -> alarm=0. The next 16 samples of 1000 produce no run_count change. The 17th sample gives run_count=1. With DETECT_HYST_EN, feat 200 keeps ALARM and feat 150 exits.
REQ-030 base=-5, feat -14 -> above=1; feat -15 -> above=0. Simultaneous base_valid (200) and feat 301 -> compared against the old baseline, so above=1.
REQ-031 rst pulsed mid-ALARM -> all outputs 0 next edge. Feat 1000 before a new baseline -> data_valid=1 with above=0.
